// File: rtl/segment_pkg.sv
// Shared display constants: default scan timing, digit-count limits, scan FSM encoding.
package segment_pkg;

  localparam int unsigned DEF_N_DIGITS    = 4;
  localparam int unsigned DEF_SCAN_DIV    = 100000;
  localparam int unsigned DEF_DEAD_CYCLES = 16;

  localparam int unsigned MIN_DIGITS = 2;
  localparam int unsigned MAX_DIGITS = 8;

  // Scan FSM encoding, kept as plain constants for compatibility with older consumers
  localparam logic [0:0] ST_DEAD = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

endpackage

// File: rtl/scan_timer.sv
// Per-slot timebase: free-running slot counter plus the DEAD/SHOW phase decode.
module scan_timer
  import segment_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = DEF_SCAN_DIV,
  parameter int unsigned DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  output logic slot_wrap,
  output logic dead_end,
  output logic in_dead
);

  localparam int unsigned    CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  DEAD_LAST = CW'(DEAD_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [0:0]    state;

  // slot_wrap/dead_end flag the edge that leaves the last cycle of the slot / dead window
  assign slot_wrap = (cnt == CNT_LAST);
  assign dead_end  = (cnt == DEAD_LAST);
  assign in_dead   = (state == ST_DEAD);

  // Slot counter: 0..SCAN_DIV-1, then back to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cnt <= '0;
    else if (slot_wrap) cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

  // Phase FSM: every slot opens dark, lights once the dead window has elapsed
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            state <= ST_DEAD;
    else if (slot_wrap) state <= ST_DEAD;
    else if (dead_end)  state <= ST_SHOW;
  end

endmodule

// File: rtl/segment_scan_controller.sv
// Multiplexed seven-segment scan controller with double-buffered digits,
// frame-aligned commit and leading-zero blanking. hex_out feeds an external decoder.
module segment_scan_controller
  import segment_pkg::*;
#(
  parameter int unsigned N_DIGITS    = DEF_N_DIGITS,
  parameter int unsigned SCAN_DIV    = DEF_SCAN_DIV,
  parameter int unsigned DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  output logic [3:0]            hex_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   digit_en_n,
  output logic                  commit
);

  if (N_DIGITS < MIN_DIGITS || N_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("segment_scan_controller: N_DIGITS out of range");
  end

  localparam int unsigned            IW       = $clog2(N_DIGITS);
  localparam logic [IW-1:0]          IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0]    ONE_HOT0 = N_DIGITS'(1);

  logic                slot_wrap, dead_end, in_dead;
  logic [IW-1:0]       idx, idx_nxt;
  logic                frame_wrap, do_commit, dead_nxt, run;
  logic                pending;
  logic [3:0]          shadow_hex  [N_DIGITS];
  logic [3:0]          active_hex  [N_DIGITS];
  logic [3:0]          act_hex_nxt [N_DIGITS];
  logic [N_DIGITS-1:0] shadow_dp, active_dp, act_dp_nxt, blank;

  scan_timer #(
    .SCAN_DIV    (SCAN_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_scan_timer (
    .clk       (clk),
    .rst       (rst),
    .slot_wrap (slot_wrap),
    .dead_end  (dead_end),
    .in_dead   (in_dead)
  );

  // Post-edge view of index, phase and active buffer: outputs are registered from
  // these so they change on the very edge that enters the new state.
  always_comb begin
    frame_wrap  = slot_wrap && (idx == IDX_LAST);
    do_commit   = frame_wrap && pending;
    idx_nxt     = idx;
    if (slot_wrap) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    dead_nxt    = slot_wrap || (in_dead && !dead_end);
    act_dp_nxt  = do_commit ? shadow_dp : active_dp;
    for (int unsigned k = 0; k < N_DIGITS; k++)
      act_hex_nxt[k] = do_commit ? shadow_hex[k] : active_hex[k];
  end

  // Leading-zero blanking: a zero, dp-less run from the top digit down; digit 0 never blanks
  always_comb begin
    blank = '0;
    run   = blank_lz;
    for (int unsigned k = N_DIGITS - 1; k >= 1; k--) begin
      run      = run && (act_hex_nxt[k] == 4'h0) && !act_dp_nxt[k];
      blank[k] = run;
    end
  end

  // Digit index advances once per slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx <= '0;
    else     idx <= idx_nxt;
  end

  // Shadow/active buffers; a load on the commit edge lands in shadow and stays pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= 1'b0;
      shadow_dp <= '0;
      active_dp <= '0;
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
        shadow_hex[k] <= '0;
        active_hex[k] <= '0;
      end
    end else begin
      active_dp <= act_dp_nxt;
      for (int unsigned k = 0; k < N_DIGITS; k++)
        active_hex[k] <= act_hex_nxt[k];
      if (load) begin
        pending   <= 1'b1;
        shadow_dp <= dp_in;
        for (int unsigned k = 0; k < N_DIGITS; k++)
          shadow_hex[k] <= digits_in[4*k +: 4];
      end else if (do_commit) begin
        pending <= 1'b0;
      end
    end
  end

  // Registered display outputs for the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_en_n <= '1;
      dp_out     <= 1'b1;
      hex_out    <= '0;
      commit     <= 1'b0;
    end else begin
      commit  <= do_commit;
      hex_out <= act_hex_nxt[idx_nxt];
      if (dead_nxt || blank[idx_nxt]) begin
        digit_en_n <= '1;
        dp_out     <= 1'b1;
      end else begin
        digit_en_n <= ~(ONE_HOT0 << idx_nxt);
        dp_out     <= ~act_dp_nxt[idx_nxt];
      end
    end
  end

endmodule

// File: tb/tb_segment_scan_controller.sv
// Directed, table-driven bench for segment_scan_controller (4 digits, 8-cycle slots, 2 dead cycles).
module tb_segment_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  hex_out;
  logic        dp_out;
  logic [3:0]  digit_en_n;
  logic        commit;

  segment_scan_controller #(
    .N_DIGITS    (4),
    .SCAN_DIV    (8),
    .DEAD_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .hex_out    (hex_out),
    .dp_out     (dp_out),
    .digit_en_n (digit_en_n),
    .commit     (commit)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // One record per digit slot: optional load (at slot cycle ld_at), blank_lz level,
  // and the expected SHOW-phase anodes/hex/dp plus commit at slot cycle 0.
  typedef struct {
    bit          ld;
    int          ld_at;
    logic [15:0] dig;
    logic [3:0]  dp;
    bit          blz;
    logic [3:0]  en;
    logic [3:0]  hx;
    bit          dpx;
    bit          cm;
  } vec_t;

  vec_t tbl[39];

  function automatic vec_t v(input bit ld, input int at, input logic [15:0] d,
                             input logic [3:0] p, input bit blz, input logic [3:0] en,
                             input logic [3:0] hx, input bit dpx, input bit cm);
    vec_t r;
    r.ld = ld; r.ld_at = at; r.dig = d; r.dp = p; r.blz = blz;
    r.en = en; r.hx = hx; r.dpx = dpx; r.cm = cm;
    return r;
  endfunction

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", nm, act, exp);
  endtask

  // Checks one 8-cycle slot; entered and left at the slot's cycle-0 sample point
  task automatic run_slot(input vec_t t, input int s);
    blank_lz = t.blz;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("s%0d c%0d en", s, c), digit_en_n, (c < 2) ? 4'b1111 : t.en);
      check($sformatf("s%0d c%0d hex", s, c), hex_out, t.hx);
      check($sformatf("s%0d c%0d dp", s, c), {3'b000, dp_out}, {3'b000, (c < 2) ? 1'b1 : t.dpx});
      check($sformatf("s%0d c%0d commit", s, c), {3'b000, commit}, {3'b000, (c == 0) ? t.cm : 1'b0});
      if (t.ld && c == t.ld_at) begin
        load = 1'b1; digits_in = t.dig; dp_in = t.dp;
      end
      @(posedge clk); #1;
      load = 1'b0;
    end
  endtask

  initial begin
    // frame 0: plain reset scan
    tbl[0]  = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1110, 4'h0, 1, 0);
    tbl[1]  = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1101, 4'h0, 1, 0);
    tbl[2]  = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1011, 4'h0, 1, 0);
    tbl[3]  = v(0, 0, 16'h0000, 4'b0000, 0, 4'b0111, 4'h0, 1, 0);
    // frame 1: load 12A5 during idx 1, display unchanged
    tbl[4]  = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1110, 4'h0, 1, 0);
    tbl[5]  = v(1, 3, 16'h12A5, 4'b0000, 0, 4'b1101, 4'h0, 1, 0);
    tbl[6]  = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1011, 4'h0, 1, 0);
    tbl[7]  = v(0, 0, 16'h0000, 4'b0000, 0, 4'b0111, 4'h0, 1, 0);
    // frame 2: committed 12A5; load 0070 during idx 3
    tbl[8]  = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1110, 4'h5, 1, 1);
    tbl[9]  = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1101, 4'hA, 1, 0);
    tbl[10] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1011, 4'h2, 1, 0);
    tbl[11] = v(1, 3, 16'h0070, 4'b0000, 1, 4'b0111, 4'h1, 1, 0);
    // frame 3: 0070 blanked above digit 1; load 0070 with dp on digit 2
    tbl[12] = v(0, 0, 16'h0000, 4'b0000, 1, 4'b1110, 4'h0, 1, 1);
    tbl[13] = v(0, 0, 16'h0000, 4'b0000, 1, 4'b1101, 4'h7, 1, 0);
    tbl[14] = v(0, 0, 16'h0000, 4'b0000, 1, 4'b1111, 4'h0, 1, 0);
    tbl[15] = v(1, 3, 16'h0070, 4'b0100, 1, 4'b1111, 4'h0, 1, 0);
    // frame 4: dp keeps digit 2 lit; blanking off for idx 3
    tbl[16] = v(0, 0, 16'h0000, 4'b0000, 1, 4'b1110, 4'h0, 1, 1);
    tbl[17] = v(0, 0, 16'h0000, 4'b0000, 1, 4'b1101, 4'h7, 1, 0);
    tbl[18] = v(0, 0, 16'h0000, 4'b0000, 1, 4'b1011, 4'h0, 0, 0);
    tbl[19] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b0111, 4'h0, 1, 0);
    // frame 5: load A in idx 2, load B on the frame-wrap edge
    tbl[20] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1110, 4'h0, 1, 0);
    tbl[21] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1101, 4'h7, 1, 0);
    tbl[22] = v(1, 3, 16'h3456, 4'b0000, 0, 4'b1011, 4'h0, 0, 0);
    tbl[23] = v(1, 7, 16'h789B, 4'b0001, 0, 4'b0111, 4'h0, 1, 0);
    // frame 6: A
    tbl[24] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1110, 4'h6, 1, 1);
    tbl[25] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1101, 4'h5, 1, 0);
    tbl[26] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1011, 4'h4, 1, 0);
    tbl[27] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b0111, 4'h3, 1, 0);
    // frame 7: B, second commit
    tbl[28] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1110, 4'hB, 0, 1);
    tbl[29] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1101, 4'h9, 1, 0);
    tbl[30] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1011, 4'h8, 1, 0);
    tbl[31] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b0111, 4'h7, 1, 0);
    // frame 8: no commit; load FFFF left pending in idx 1
    tbl[32] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1110, 4'hB, 0, 0);
    tbl[33] = v(1, 3, 16'hFFFF, 4'b1111, 0, 4'b1101, 4'h9, 1, 0);
    // after mid-frame reset: zeros, pending load discarded
    tbl[34] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1110, 4'h0, 1, 0);
    tbl[35] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1101, 4'h0, 1, 0);
    tbl[36] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1011, 4'h0, 1, 0);
    tbl[37] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b0111, 4'h0, 1, 0);
    tbl[38] = v(0, 0, 16'h0000, 4'b0000, 0, 4'b1110, 4'h0, 1, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst en", digit_en_n, 4'b1111);
    check("rst hex", hex_out, 4'h0);
    check("rst dp", {3'b000, dp_out}, 4'b0001);
    check("rst commit", {3'b000, commit}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 34; i++) run_slot(tbl[i], i);

    // frame 8, idx 2: run into SHOW, then reset asynchronously with FFFF pending
    for (int c = 0; c < 5; c++) begin
      check($sformatf("pre-rst c%0d en", c), digit_en_n, (c < 2) ? 4'b1111 : 4'b1011);
      check($sformatf("pre-rst c%0d hex", c), hex_out, 4'h8);
      check($sformatf("pre-rst c%0d dp", c), {3'b000, dp_out}, 4'b0001);
      if (c < 4) begin
        @(posedge clk); #1;
      end
    end
    #2 rst = 1'b1;
    #1;
    check("async rst en", digit_en_n, 4'b1111);
    check("async rst hex", hex_out, 4'h0);
    check("async rst dp", {3'b000, dp_out}, 4'b0001);
    check("async rst commit", {3'b000, commit}, 4'b0000);
    @(posedge clk); #1;
    check("held rst en", digit_en_n, 4'b1111);
    check("held rst hex", hex_out, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 34; i < 39; i++) run_slot(tbl[i], i);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/segment_scan_controller.md
SEGMENT_SCAN_CONTROLLER -- requirements
Module: segment_scan_controller

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4: number of multiplexed digits (2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 100000: clk cycles per digit slot.
REQ-003 SHALL have parameter DEAD_CYCLES, default 16: anode-off cycles at slot start; legal range 1 <= DEAD_CYCLES < SCAN_DIV.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port load, input, 1 bit: single-cycle strobe; writes digits_in and dp_in into the shadow buffer.
REQ-007 SHALL have port digits_in, input, 4*N_DIGITS bits: nibble k is the hex value of digit k; digit 0 is least significant.
REQ-008 SHALL have port dp_in, input, N_DIGITS bits: decimal point request per digit, 1 = lit.
REQ-009 SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking.
REQ-010 SHALL have port hex_out, output, 4 bits: current digit value, to the external seven-segment decoder.
REQ-011 SHALL have port dp_out, output, 1 bit: decimal point, active-low.
REQ-012 SHALL have port digit_en_n, output, N_DIGITS bits: digit anode enables, active-low, at most one low at a time.
REQ-013 SHALL have port commit, output, 1 bit: one-cycle pulse when the shadow buffer is copied to the active buffer.

Function
REQ-014 SHALL keep a free-running slot counter cnt counting 0..SCAN_DIV-1, then wrapping to 0.
REQ-015 SHALL keep a digit index idx that increments when cnt wraps and goes from N_DIGITS-1 back to 0.
REQ-016 SHALL run a two-state FSM:
  - DEAD while cnt < DEAD_CYCLES.
  - SHOW otherwise.
  - DEAD->SHOW when cnt reaches DEAD_CYCLES.
  - SHOW->DEAD when cnt wraps.
REQ-017 SHALL register every output; an output SHALL take the value for a state on the same edge that enters that state.
REQ-018 SHALL, in DEAD, drive digit_en_n all ones and dp_out = 1; hex_out SHALL hold the value of the new idx.
REQ-019 SHALL, in SHOW, drive digit_en_n[idx] = 0 unless digit idx is blanked, hex_out = active nibble idx, and dp_out = ~active_dp[idx].
REQ-020 SHALL, with blank_lz = 1, blank digit k (k >= 1) when digit k and every higher digit are zero in the active buffer.
  - Digit 0 is never blanked.
  - A lit dp on digit k prevents blanking of digit k and of every lower digit.
REQ-021 SHALL, for a blanked digit, keep all anodes off and dp_out = 1 for the whole slot; slot timing SHALL be unchanged.
REQ-022 SHALL, on load, overwrite the shadow buffer and set a pending flag.
  - A load while pending is already set overwrites the shadow buffer; the last write wins.
REQ-023 SHALL copy shadow to active, clear pending and pulse commit on the edge where idx wraps N_DIGITS-1 -> 0, only if pending is set.
  - This keeps a frame tear-free.
REQ-024 SHALL, when load coincides with the commit edge, commit the old shadow contents and leave pending set holding the new data.
REQ-025 SHALL sample blank_lz combinationally each cycle; it SHALL take no part in the commit mechanism.

Reset
REQ-026 SHALL, while rst = 1, force:
  - cnt = 0, idx = 0, state DEAD;
  - digit_en_n all ones, dp_out = 1, hex_out = 0, commit = 0;
  - shadow and active buffers zero, pending = 0.
REQ-027 SHALL, on rst deassertion, restart at slot 0, cnt 0, DEAD.
  - A reset asserted mid-frame SHALL discard any pending load.

Structure
REQ-028 SHALL take its default timing constants and the digit-count limit from a shared display package, segment_pkg.
REQ-029 SHALL place the slot counter and the DEAD/SHOW decode in one sub-module, scan_timer, with outputs slot_wrap and in_dead.
REQ-030 SHALL leave the seven-segment decoder outside this block; hex_out connects to it directly.

Verification
Bench parameters: N_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2.
REQ-031 SHALL cover the reset scan with no load.
  - Stimulus: release rst, run 32 cycles.
  - Response: digit_en_n = 1111 for 2 cycles, then 1110 for 6; then 1101, 1011, 0111 in the same pattern; hex_out = 0 throughout.
REQ-032 SHALL cover load and commit.
  - Stimulus: load digits_in = 16'h12A5 at idx 1.
  - Response: display unchanged until the idx 3->0 wrap; commit pulses once; then the slots show 5, A, 2, 1.
REQ-033 SHALL cover leading-zero blanking.
  - Stimulus: active value 16'h0070, blank_lz = 1.
  - Response: digits 3 and 2 are never enabled; digits 1 and 0 show 7 and 0.
  - Stimulus: set dp_in = 4'b0100.
  - Response: digit 2 is shown as 0 with dp_out = 0.
REQ-034 SHALL cover load coinciding with commit.
  - Stimulus: load A pending; load B on the wrap edge.
  - Response: A is shown in frame 1, B in frame 2, with two separate commit pulses.
REQ-035 SHALL cover reset mid-operation.
  - Stimulus: assert rst during a SHOW of idx 2 with a load pending.
  - Response: outputs go to reset values immediately (asynchronously); after release, digits show 0 and no commit occurs.
